// File: rtl/uart_share_ctrl.sv
// uart_share_ctrl: two-requester arbiter sharing one UART transmitter.
// Programs the baud divider once after reset, then forwards packets.
module uart_share_ctrl #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int LOCK_TO   = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic [3:0]  uart_div_we,
  output logic [31:0] uart_div_di,
  output logic        uart_dat_we,
  output logic [31:0] uart_dat_di,
  input  logic        uart_dat_wait,
  output logic [1:0]  grant,
  output logic        cfg_busy
);

  localparam longint DIV_L =
    longint'(CLK_FRE) * 1000000 / longint'(BAUD_RATE);
  localparam logic [31:0] DIV = DIV_L[31:0];
  localparam int CW = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    SEND,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          in_rst;
  logic          rr;
  logic          last_q;
  logic [7:0]    byte_q;
  logic [CW-1:0] idle_cnt;

  logic both;
  logic sel1;
  logic take;
  logic lock_hit;
  logic div_go;
  logic sent;

  assign both     = req0_valid & req1_valid;
  assign sel1     = both ? rr : req1_valid;
  assign take     = req0_ready | req1_ready;
  assign lock_hit = idle_cnt == CW'(LOCK_TO - 1);
  assign sent     = (state == SEND) & ~uart_dat_wait;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = req0_valid & ~sel1;
        req1_ready = req1_valid & sel1;
      end
      HOLD: begin
        req0_ready = grant[0] & req0_valid;
        req1_ready = grant[1] & req1_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      INIT: if (!in_rst) state_n = IDLE;
      IDLE: if (take) state_n = SEND;
      SEND: begin
        if (!uart_dat_wait) state_n = last_q ? IDLE : HOLD;
      end
      HOLD: begin
        if (take) state_n = SEND;
        else if (lock_hit) state_n = IDLE;
      end
      default: state_n = INIT;
    endcase
  end

  // in_rst keeps the divider write out of the reset cycles themselves
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= INIT;
      in_rst <= 1'b1;
    end else begin
      state  <= state_n;
      in_rst <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant    <= 2'b00;
      rr       <= 1'b0;
      byte_q   <= 8'h00;
      last_q   <= 1'b0;
      idle_cnt <= '0;
    end else if (take) begin
      byte_q   <= req1_ready ? req1_data : req0_data;
      last_q   <= req1_ready ? req1_last : req0_last;
      grant    <= {req1_ready, req0_ready};
      idle_cnt <= '0;
    end else if (sent) begin
      idle_cnt <= '0;
      if (last_q) begin
        grant <= 2'b00;
        rr    <= ~grant[1];
      end
    end else if (state == HOLD) begin
      if (lock_hit) begin
        grant    <= 2'b00;
        rr       <= ~grant[1];
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end

  assign div_go      = (state == INIT) & ~in_rst;
  assign uart_div_we = div_go ? 4'hF : 4'h0;
  assign uart_div_di = div_go ? DIV : 32'h0;
  assign uart_dat_we = state == SEND;
  assign uart_dat_di = {24'h0, byte_q};
  assign cfg_busy    = state == INIT;

endmodule

// File: tb/tb_uart_share_ctrl.sv
// Bench for uart_share_ctrl: packet-level arbitration model, UART
// write scoreboard, directed corner cases and random traffic.
module tb_uart_share_ctrl;

  localparam int LOCK = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_last, req1_last;
  logic        req0_ready, req1_ready;
  logic [3:0]  uart_div_we;
  logic [31:0] uart_div_di;
  logic        uart_dat_we;
  logic [31:0] uart_dat_di;
  logic        uart_dat_wait;
  logic [1:0]  grant;
  logic        cfg_busy;

  always #5 clk = ~clk;

  uart_share_ctrl #(.LOCK_TO(LOCK)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_last    (req0_last),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_last    (req1_last),
    .req1_ready   (req1_ready),
    .uart_div_we  (uart_div_we),
    .uart_div_di  (uart_div_di),
    .uart_dat_we  (uart_dat_we),
    .uart_dat_di  (uart_dat_di),
    .uart_dat_wait(uart_dat_wait),
    .grant        (grant),
    .cfg_busy     (cfg_busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         gap;
  } item_t;

  item_t      q0[$];
  item_t      q1[$];
  logic [7:0] exp_q[$];
  logic [1:0] acc_g[$];
  logic [7:0] acc_d[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int hold_cycles = 0;

  // reference model: who owns the UART and whose turn it is
  int         owner;
  int         rr_m;
  int         idle;
  bit         inflight;
  bit         cur_last;
  logic [1:0] m_er, m_eg;
  logic       m_h0, m_h1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!mon_en) begin
      owner = -1; rr_m = 0; idle = 0;
      inflight = 0; cur_last = 0;
      exp_q.delete();
    end else begin
      if (inflight) m_er = 2'b00;
      else if (owner < 0)
        m_er = (req0_valid & req1_valid) ?
               ((rr_m != 0) ? 2'b10 : 2'b01) :
               {req1_valid, req0_valid};
      else if (owner == 1) m_er = {req1_valid, 1'b0};
      else m_er = {1'b0, req0_valid};
      m_eg = (owner < 0) ? 2'b00 : ((owner == 1) ? 2'b10 : 2'b01);
      check("ready", 32'({req1_ready, req0_ready}), 32'(m_er));
      check("grant", 32'(grant), 32'(m_eg));
      check("dat_we", 32'(uart_dat_we), 32'(inflight));
      check("div_we_idle", 32'(uart_div_we), 32'd0);
      check("cfg_busy_idle", 32'(cfg_busy), 32'd0);
      if (inflight && exp_q.size() != 0)
        check("dat_di_hold", uart_dat_di, {24'h0, exp_q[0]});
      m_h0 = req0_valid & req0_ready;
      m_h1 = req1_valid & req1_ready;
      if (m_h0 | m_h1) begin
        exp_q.push_back(m_h1 ? req1_data : req0_data);
        cur_last = m_h1 ? req1_last : req0_last;
        owner = m_h1 ? 1 : 0;
        inflight = 1; idle = 0;
      end else if (inflight && !uart_dat_wait) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check("sb_data", uart_dat_di, {24'h0, exp_q.pop_front()});
        acc_g.push_back(grant);
        acc_d.push_back(uart_dat_di[7:0]);
        inflight = 0; idle = 0;
        if (cur_last) begin rr_m = 1 - owner; owner = -1; end
      end else if (owner >= 0 && !inflight) begin
        idle++; hold_cycles++;
        if (idle == LOCK) begin
          rr_m = 1 - owner; owner = -1; idle = 0;
        end
      end
    end
  end

  task automatic present(inout int g0, inout int g1);
    req0_valid = (q0.size() != 0) && (g0 == 0);
    req1_valid = (q1.size() != 0) && (g1 == 0);
    if (q0.size() != 0) begin req0_data = q0[0].d; req0_last = q0[0].l; end
    if (q1.size() != 0) begin req1_data = q1[0].d; req1_last = q1[0].l; end
    if (g0 > 0) g0--;
    if (g1 > 0) g1--;
  endtask

  task automatic run_traffic(input string tag, input int wait_pct,
                             input int budget);
    int cyc, g0, g1;
    logic h0, h1;
    cyc = 0;
    acc_g.delete(); acc_d.delete(); hold_cycles = 0;
    g0 = (q0.size() != 0) ? q0[0].gap : 0;
    g1 = (q1.size() != 0) ? q1[0].gap : 0;
    present(g0, g1);
    uart_dat_wait = 1'b0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 ||
            grant != 2'b00) && cyc < budget) begin
      @(negedge clk);
      h0 = req0_valid & req0_ready;
      h1 = req1_valid & req1_ready;
      @(posedge clk); #1;
      if (h0) begin q0.delete(0); g0 = (q0.size() != 0) ? q0[0].gap : 0; end
      if (h1) begin q1.delete(0); g1 = (q1.size() != 0) ? q1[0].gap : 0; end
      present(g0, g1);
      uart_dat_wait = int'($urandom_range(0, 99)) < wait_pct;
      cyc++;
    end
    uart_dat_wait = 1'b0;
    check({tag, "_done_in_budget"}, 32'(cyc < budget), 32'd1);
  endtask

  task automatic push_item(input int r, input logic [7:0] d,
                           input logic l, input int gap);
    item_t it;
    it.d = d; it.l = l; it.gap = gap;
    if (r == 0) q0.push_back(it);
    else q1.push_back(it);
  endtask

  task automatic check_order(input string tag, input logic [1:0] eg[$],
                             input logic [7:0] ed[$]);
    check({tag, "_count"}, 32'(acc_g.size()), 32'(eg.size()));
    for (int i = 0; i < eg.size(); i++) begin
      if (i < acc_g.size()) begin
        check({tag, "_owner"}, 32'(acc_g[i]), 32'(eg[i]));
        check({tag, "_byte"}, 32'(acc_d[i]), 32'(ed[i]));
      end
    end
  endtask

  task automatic init_checks(input string tag);
    @(posedge clk); @(negedge clk);
    check({tag, "_div_we"}, 32'(uart_div_we), 32'hF);
    check({tag, "_div_di"}, uart_div_di, 32'd434);
    check({tag, "_busy"}, 32'(cfg_busy), 32'd1);
    check({tag, "_ready"}, 32'({req1_ready, req0_ready}), 32'd0);
    @(negedge clk);
    check({tag, "_div_we_off"}, 32'(uart_div_we), 32'd0);
    check({tag, "_busy_off"}, 32'(cfg_busy), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
  endtask

  task automatic gen_random(output int total);
    int len;
    total = 0;
    for (int p = 0; p < 6; p++) begin
      for (int r = 0; r < 2; r++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          push_item(r, 8'($urandom), b == len - 1,
                    ($urandom_range(0, 3) == 0) ?
                    int'($urandom_range(4, 12)) :
                    int'($urandom_range(0, 2)));
          total++;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_n, total;
    resetn = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h00; req1_data = 8'h00;
    req0_last = 1'b0; req1_last = 1'b0;
    uart_dat_wait = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dat_we", 32'(uart_dat_we), 32'd0);
    check("rst_div_we", 32'(uart_div_we), 32'd0);
    check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    init_checks("init");
    @(posedge clk); #1;
    mon_en = 1'b1;

    // both always valid, last on every byte: strict alternation from req0
    push_item(0, 8'h10, 1'b1, 0); push_item(0, 8'h12, 1'b1, 0);
    push_item(1, 8'h11, 1'b1, 0); push_item(1, 8'h13, 1'b1, 0);
    run_traffic("alt", 0, 200);
    check_order("alt", '{2'b01, 2'b10, 2'b01, 2'b10},
                '{8'h10, 8'h11, 8'h12, 8'h13});

    // single byte stalled by the UART for three cycles
    req0_valid = 1'b1; req0_data = 8'h41; req0_last = 1'b1;
    uart_dat_wait = 1'b1;
    we_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (uart_dat_we) begin
        we_n++;
        check("stall_di", uart_dat_di, 32'h41);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      uart_dat_wait = we_n < 3;
    end
    check("stall_we_cycles", 32'(we_n), 32'd4);
    check("stall_grant", 32'(grant), 32'd0);

    // req1 packet "AB" holds the UART although req0 waits throughout
    push_item(0, 8'h58, 1'b1, 0); push_item(0, 8'h59, 1'b1, 0);
    push_item(1, 8'h41, 1'b0, 0); push_item(1, 8'h42, 1'b1, 0);
    run_traffic("pkt", 0, 200);
    check_order("pkt", '{2'b10, 2'b10, 2'b01, 2'b01},
                '{8'h41, 8'h42, 8'h58, 8'h59});

    // owner goes silent mid-packet: lock released after LOCK idle cycles
    push_item(0, 8'h70, 1'b0, 0);
    push_item(1, 8'h71, 1'b1, 2);
    run_traffic("lock", 0, 200);
    check_order("lock", '{2'b01, 2'b10}, '{8'h70, 8'h71});
    check("lock_hold_cycles", 32'(hold_cycles), 32'(LOCK));

    // reset while a byte is stalled in the UART
    mon_en = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h99; req0_last = 1'b1;
    uart_dat_wait = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("rs_in_send", 32'(uart_dat_we), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rs_dat_we", 32'(uart_dat_we), 32'd0);
    check("rs_grant", 32'(grant), 32'd0);
    check("rs_ready", 32'({req1_ready, req0_ready}), 32'd0);
    check("rs_busy", 32'(cfg_busy), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    uart_dat_wait = 1'b0;
    init_checks("reinit");
    @(posedge clk); #1;
    mon_en = 1'b1;

    gen_random(total);
    run_traffic("rand", 30, 20000);
    check("rand_bytes", 32'(acc_d.size()), 32'(total));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_share_ctrl.md
UART_SHARE_CTRL -- requirements
Module: uart_share_ctrl

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, meaning system clock in MHz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial baud rate.
REQ-003 SHALL have parameter LOCK_TO, default 1024, meaning idle cycles before a held packet grant is revoked.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port resetn, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have ports req0_valid / req1_valid, input, 1, requester has a byte.
REQ-007 SHALL have ports req0_data / req1_data, input, 8, byte to transmit.
REQ-008 SHALL have ports req0_last / req1_last, input, 1, byte ends packet and releases the grant.
REQ-009 SHALL have ports req0_ready / req1_ready, output, 1, byte accepted this cycle.
REQ-010 SHALL have port uart_div_we, output, 4, byte enables for the UART divider register.
REQ-011 SHALL have port uart_div_di, output, 32, divider write data.
REQ-012 SHALL have port uart_dat_we, output, 1, UART data write strobe.
REQ-013 SHALL have port uart_dat_di, output, 32, UART data write value.
REQ-014 SHALL have port uart_dat_wait, input, 1, UART stalls the current data write.
REQ-015 SHALL have port grant, output, 2, one-hot current owner; 00 means none.
REQ-016 SHALL have port cfg_busy, output, 1, divider initialisation not yet done.

Function
REQ-017 SHALL use FSM states INIT, IDLE, SEND and HOLD.
REQ-018 SHALL, in INIT, drive uart_div_we=4'hF and uart_div_di=CLK_FRE*1000000/BAUD_RATE (32-bit, truncating) for exactly one cycle, then enter IDLE.
REQ-019 SHALL deassert cfg_busy from the first IDLE cycle onward.
REQ-020 SHALL hold uart_div_we at 0 in every state other than INIT.
REQ-021 SHALL, in IDLE, select the valid requester; if both are valid, it selects the requester named by the 1-bit round-robin pointer rr.
REQ-022 SHALL, in IDLE, assert ready combinationally for the selected requester only, latch its data and last, set grant, and enter SEND on the next cycle.
REQ-023 SHALL, in SEND, drive uart_dat_we=1 and uart_dat_di={24'h0, latched byte}, holding both stable while uart_dat_wait=1.
REQ-024 SHALL treat the write as accepted in the first SEND cycle where uart_dat_wait=0.
REQ-025 SHALL, when the accepted byte had last=1, clear grant, set rr to the other requester, and enter IDLE.
REQ-026 SHALL, when the accepted byte had last=0, enter HOLD with grant kept.
REQ-027 SHALL, in HOLD, assert ready only for the owner, and only while its valid=1; a transfer relatches and re-enters SEND.
REQ-028 SHALL ignore the non-owner entirely in HOLD, even if it is valid.
REQ-029 SHALL run an idle counter in HOLD: it is cleared on entry and on each transfer, and increments each cycle the owner's valid=0.
REQ-030 SHALL, when the idle counter reaches LOCK_TO-1, release the grant, set rr to the other requester, and enter IDLE.
REQ-031 SHALL never assert both ready outputs in the same cycle.
REQ-032 SHALL keep ready at 0 in INIT and SEND.
REQ-033 SHALL, when a single requester is valid in IDLE, grant it regardless of rr.
REQ-034 SHALL derive all outputs from registered state, except reqN_ready, which is combinational from state and the valid inputs.

Reset
REQ-035 SHALL, on clk with resetn=0, enter INIT and drive: uart_dat_we=0, uart_div_we=0, both ready=0, grant=00, cfg_busy=1, rr=0, idle counter=0.
REQ-036 SHALL, on reset mid-SEND or mid-HOLD, drop the pending byte and any grant without completing them.
REQ-037 SHALL perform INIT (one divider write) in the first cycle after resetn returns to 1.

Verification
REQ-038 Bench SHALL cover: release reset with defaults -> one cycle uart_div_we=F, uart_div_di=434, then cfg_busy=0.
REQ-039 Bench SHALL cover: req0 sends 0x41 with last=1, uart_dat_wait high 3 cycles -> uart_dat_we held 4 cycles with di=0x41, grant returns to 00, rr=1.
REQ-040 Bench SHALL cover: both requesters valid continuously with last=1 on every byte -> accepted order alternates 0,1,0,1 starting at req0.
REQ-041 Bench SHALL cover: req1 sends "AB" (last only on 'B') while req0 is valid throughout -> UART sees 'A','B' back-to-back before any req0 byte.
REQ-042 Bench SHALL cover: owner goes silent in HOLD with LOCK_TO=8 -> grant released after 8 idle cycles, and the other requester is served next.
REQ-043 Bench SHALL cover: resetn=0 during SEND -> uart_dat_we=0 and grant=00 next cycle; after release, INIT repeats.
